// File: rtl/counter_pkg.sv
// counter_pkg: shared widths and limits for the one-shot down counter
package counter_pkg;
    localparam int COUNT_W = 3;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 3'b111;
    localparam logic [COUNT_W-1:0] COUNT_MIN = 3'b000;
    localparam int FILT_W = 8;
endpackage

// File: rtl/input_oneshot.sv
// input_oneshot: synchronizes a raw level, optionally debounces it (DOWN_COUNTER_DEBOUNCE_EN), emits one pulse per rising edge
module input_oneshot
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic pulse
);
    logic sync_q1;
    logic sync_q2;
    logic level;
    logic prev_level;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES out of range 1..255");
    end

    // two-flop synchronizer for the asynchronous raw input
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

`ifdef DOWN_COUNTER_DEBOUNCE_EN
    logic [FILT_W-1:0] filt_cnt;
    logic [FILT_W-1:0] cnt_inc;

    assign cnt_inc = filt_cnt + 1'b1;

    // accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level    <= 1'b0;
            filt_cnt <= '0;
        end else if (sync_q2 == level) begin
            filt_cnt <= '0;
        end else if (cnt_inc == FILT_W'(DEBOUNCE_CYCLES)) begin
            level    <= sync_q2;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= cnt_inc;
        end
    end
`else
    assign level = sync_q2;
`endif

    // remember last level so only a 0->1 transition yields a pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) prev_level <= 1'b0;
        else          prev_level <= level;
    end

    assign pulse = level & ~prev_level;
endmodule

// File: rtl/down_counter_oneshot.sv
// down_counter_oneshot: 3-bit loadable down counter stepped by debounced button presses (filter under DOWN_COUNTER_DEBOUNCE_EN)
module down_counter_oneshot
    import counter_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               input_sm2,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_value,
    output logic [COUNT_W-1:0] state,
    output logic               underflow,
    output logic               dec_pulse
);
    logic dec_event;
    logic take_dec;

    input_oneshot #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_oneshot (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (input_sm2),
        .pulse  (dec_event)
    );

    assign take_dec = dec_event & ~load;

    // load has priority; a coincident event is dropped, wrap 000->111 flags underflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= COUNT_MIN;
            underflow <= 1'b0;
            dec_pulse <= 1'b0;
        end else begin
            state     <= load ? load_value : take_dec ? (state == COUNT_MIN ? COUNT_MAX : state - 1'b1) : state;
            dec_pulse <= take_dec;
            underflow <= take_dec & (state == COUNT_MIN);
        end
    end
endmodule
